mem_port_arbiter: RTL and testbench

Sequencer and arbiter that shares the core's single-port unified memory between the instruction-fetch stage and the load/store path driven by the decoded `mem_read`/`mem_write` controls. It owns the memory handshake: it grants one requester, issues one memory access, waits for completion, and returns a one-cycle acknowledge with read data. The pipeline stalls on its own pending request until that acknowledge arrives.

---
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester/memory bundle shared by the fetch stage, the load/store path and the memory port.
// The slave modport is the arbiter's view; master is the opposite side.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_flush;
  logic [DW-1:0]   if_rdata;
  logic            if_ack;
  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_be;
  logic [DW-1:0]   d_rdata;
  logic            d_ack;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_be;
  logic [DW-1:0]   mem_rdata;
  logic            mem_ready;

  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_ready,
    output if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_ready,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, one access in flight.
// Define ARB_STARVE_GUARD_EN to bound consecutive data grants while a fetch waits (STREAK_MAX).
module mem_port_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
`ifdef ARB_STARVE_GUARD_EN
  ,
  parameter int unsigned STREAK_MAX = 4
`endif
) (
  input logic              clk,
  input logic              rst_n,
  mem_port_arbiter_if.slave io_bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e          r_state, w_state_d;
  logic            r_own_if;
  logic            r_drop;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW/8-1:0] r_be;
  logic [DW-1:0]   r_rdata;

  logic w_grant_if;
  logic w_grant_d;
  logic w_force_if;
  logic w_drop_d;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STREAK_MAX + 1);
  logic [SW-1:0] r_streak, w_streak_d;

  assign w_force_if = io_bus.if_req && (r_streak == SW'(STREAK_MAX));

  always_comb begin
    w_streak_d = r_streak;
    if (w_grant_if) begin
      w_streak_d = '0;
    end else if (w_grant_d) begin
      if (!io_bus.if_req) begin
        w_streak_d = '0;
      end else if (r_streak != SW'(STREAK_MAX)) begin
        w_streak_d = r_streak + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= '0;
    end else begin
      r_streak <= w_streak_d;
    end
  end
`else
  assign w_force_if = 1'b0;
`endif

  // Grants only exist in IDLE; data is the older instruction and wins unless forced.
  always_comb begin
    w_grant_if = 1'b0;
    w_grant_d  = 1'b0;
    if (r_state == StIdle) begin
      w_grant_if = io_bus.if_req && (!io_bus.d_req || w_force_if);
      w_grant_d  = io_bus.d_req && !w_grant_if;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_grant_if || w_grant_d) w_state_d = StIssue;
      StIssue: w_state_d = StWait;
      StWait:  if (io_bus.mem_ready) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_drop_d = 1'b0;
    if (r_state != StIdle) begin
      w_drop_d = r_drop || (r_own_if && io_bus.if_flush);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_own_if <= 1'b0;
      r_drop   <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_rdata  <= '0;
    end else begin
      r_state <= w_state_d;
      r_drop  <= w_drop_d;
      if (w_grant_d) begin
        r_own_if <= 1'b0;
        r_we     <= io_bus.d_we;
        r_addr   <= io_bus.d_addr;
        r_wdata  <= io_bus.d_wdata;
        r_be     <= io_bus.d_be;
      end else if (w_grant_if) begin
        r_own_if <= 1'b1;
        r_we     <= 1'b0;
        r_addr   <= io_bus.if_addr;
        r_wdata  <= '0;
        r_be     <= '1;
      end
      if (r_state == StWait && io_bus.mem_ready) begin
        r_rdata <= io_bus.mem_rdata;
      end
    end
  end

  assign io_bus.mem_en    = (r_state == StIssue);
  assign io_bus.mem_we    = r_we;
  assign io_bus.mem_addr  = r_addr;
  assign io_bus.mem_wdata = r_wdata;
  assign io_bus.mem_be    = r_be;

  // A flush arriving in the DONE cycle itself must still swallow the ack.
  assign io_bus.if_ack   = (r_state == StDone) && r_own_if && !r_drop && !io_bus.if_flush;
  assign io_bus.d_ack    = (r_state == StDone) && !r_own_if;
  assign io_bus.if_rdata = r_rdata;
  assign io_bus.d_rdata  = r_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store, contention, flush, mid-access reset and
// fetch starvation with and without ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   mem_lat = 1;
  logic [31:0] mem_data = '0;
  int   n_mem_en = 0;
  int   en0;
  bit   log_en = 1'b0;
  logic ack_log[$];
  int   n_fetch;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  // Memory: mem_ready for one cycle, L cycles after the mem_en cycle.
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_en === 1'b1) begin
        repeat (mem_lat) @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mem_data;
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.mem_en === 1'b1) n_mem_en++;
    if (log_en) begin
      if (bus.d_ack === 1'b1) ack_log.push_back(1'b0);
      if (bus.if_ack === 1'b1) ack_log.push_back(1'b1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.if_flush = 1'b0;
    bus.d_req    = 1'b0;
    bus.d_we     = 1'b0;
    bus.d_addr   = '0;
    bus.d_wdata  = '0;
    bus.d_be     = '0;
    repeat (2) tick();
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_if_ack", bus.if_ack, 0);
    chk("rst_d_ack", bus.d_ack, 0);
    chk("rst_rdata", bus.d_rdata, 0);
    rst_n = 1'b1;

    // Single fetch, L=1
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h100; mem_lat = 1; mem_data = 32'hDEADBEEF;
    en0 = n_mem_en;
    #1 chk("t1_c0_en", bus.mem_en, 0);
    tick(); #1;
    chk("t1_c1_en", bus.mem_en, 1);
    chk("t1_c1_addr", bus.mem_addr, 32'h100);
    chk("t1_c1_we", bus.mem_we, 0);
    tick(); #1;
    chk("t1_c2_en", bus.mem_en, 0);
    chk("t1_c2_ack", bus.if_ack, 0);
    tick(); #1;
    chk("t1_c3_ack", bus.if_ack, 1);
    chk("t1_c3_rdata", bus.if_rdata, 32'hDEADBEEF);
    chk("t1_c3_dack", bus.d_ack, 0);
    tick();
    bus.if_req = 1'b0;
    #1 chk("t1_c4_ack", bus.if_ack, 0);
    chk("t1_en_count", n_mem_en - en0, 1);

    // Store, L=4
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h2004;
    bus.d_wdata = 32'h12345678; bus.d_be = 4'b0011;
    mem_lat = 4; mem_data = 32'hCAFEF00D; en0 = n_mem_en;
    tick(); #1;
    chk("t2_c1_en", bus.mem_en, 1);
    chk("t2_c1_we", bus.mem_we, 1);
    chk("t2_c1_be", bus.mem_be, 4'b0011);
    chk("t2_c1_addr", bus.mem_addr, 32'h2004);
    chk("t2_c1_wdata", bus.mem_wdata, 32'h12345678);
    repeat (4) tick();
    #1 chk("t2_c5_dack", bus.d_ack, 0);
    chk("t2_c5_en", bus.mem_en, 0);
    tick(); #1;
    chk("t2_c6_dack", bus.d_ack, 1);
    chk("t2_c6_rdata", bus.d_rdata, 32'hCAFEF00D);
    chk("t2_c6_ifack", bus.if_ack, 0);
    tick();
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    #1 chk("t2_c7_dack", bus.d_ack, 0);
    chk("t2_en_count", n_mem_en - en0, 1);

    // Simultaneous requests: data first, fetch after
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    bus.d_req = 1'b1; bus.d_addr = 32'h400; bus.d_be = 4'b1111;
    mem_lat = 1; mem_data = 32'h11111111;
    tick(); #1;
    chk("t3_c1_en", bus.mem_en, 1);
    chk("t3_c1_addr", bus.mem_addr, 32'h400);
    tick();
    tick(); #1;
    chk("t3_c3_dack", bus.d_ack, 1);
    chk("t3_c3_drdata", bus.d_rdata, 32'h11111111);
    chk("t3_c3_ifack", bus.if_ack, 0);
    tick();
    bus.d_req = 1'b0; mem_data = 32'h22222222;
    #1 chk("t3_c4_en", bus.mem_en, 0);
    tick(); #1;
    chk("t3_c5_en", bus.mem_en, 1);
    chk("t3_c5_addr", bus.mem_addr, 32'h300);
    tick();
    tick(); #1;
    chk("t3_c7_ifack", bus.if_ack, 1);
    chk("t3_c7_rdata", bus.if_rdata, 32'h22222222);
    tick();
    bus.if_req = 1'b0;

    // Flush during WAIT drops the fetch ack
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h500; mem_lat = 2; mem_data = 32'h33333333;
    tick(); #1;
    chk("t4_c1_en", bus.mem_en, 1);
    tick();
    bus.if_flush = 1'b1; bus.if_req = 1'b0;
    tick();
    bus.if_flush = 1'b0;
    #1 chk("t4_c3_ack", bus.if_ack, 0);
    tick(); #1;
    chk("t4_c4_ack", bus.if_ack, 0);
    chk("t4_c4_dack", bus.d_ack, 0);
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h200; mem_lat = 1; mem_data = 32'h44444444;
    #1 chk("t4_c5_en", bus.mem_en, 0);
    tick(); #1;
    chk("t4_c6_en", bus.mem_en, 1);
    chk("t4_c6_addr", bus.mem_addr, 32'h200);
    tick();
    tick(); #1;
    chk("t4_c8_ack", bus.if_ack, 1);
    chk("t4_c8_rdata", bus.if_rdata, 32'h44444444);
    tick();
    bus.if_req = 1'b0;

    // Reset during WAIT of a load
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h600; bus.d_be = 4'b0101;
    mem_lat = 3; mem_data = 32'h55555555;
    tick(); #1;
    chk("t5_c1_en", bus.mem_en, 1);
    tick();
    rst_n = 1'b0; bus.d_req = 1'b0;
    #1;
    chk("t5_rst_en", bus.mem_en, 0);
    chk("t5_rst_addr", bus.mem_addr, 0);
    chk("t5_rst_we", bus.mem_we, 0);
    chk("t5_rst_be", bus.mem_be, 0);
    chk("t5_rst_wdata", bus.mem_wdata, 0);
    chk("t5_rst_dack", bus.d_ack, 0);
    chk("t5_rst_drdata", bus.d_rdata, 0);
    chk("t5_rst_ifrdata", bus.if_rdata, 0);
    tick();
    rst_n = 1'b1;
    tick(); #1;
    chk("t5_c4_dack", bus.d_ack, 0);
    tick(); #1;
    chk("t5_c5_dack", bus.d_ack, 0);
    chk("t5_c5_en", bus.mem_en, 0);
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h700; mem_lat = 1; mem_data = 32'h66666666;
    tick(); #1;
    chk("t5_c7_en", bus.mem_en, 1);
    chk("t5_c7_addr", bus.mem_addr, 32'h700);
    tick();
    tick(); #1;
    chk("t5_c9_ack", bus.if_ack, 1);
    chk("t5_c9_rdata", bus.if_rdata, 32'h66666666);
    tick();
    bus.if_req = 1'b0;

    // Continuous data traffic with a waiting fetch
    tick();
    ack_log.delete();
    log_en = 1'b1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h800;
    bus.if_req = 1'b1; bus.if_addr = 32'h900; mem_lat = 1; mem_data = 32'h77777777;
`ifdef ARB_STARVE_GUARD_EN
    for (int k = 0; k < 200 && ack_log.size() < 6; k++) tick();
    chk("t6_ack_count", ack_log.size() >= 6, 1);
    for (int k = 0; k < 4; k++) chk($sformatf("t6_ack%0d_data", k), ack_log[k], 0);
    chk("t6_ack4_fetch", ack_log[4], 1);
    chk("t6_ack5_data", ack_log[5], 0);
`else
    for (int k = 0; k < 400 && ack_log.size() < 20; k++) tick();
    chk("t6_ack_count", ack_log.size() >= 20, 1);
    n_fetch = 0;
    for (int k = 0; k < 20; k++) if (ack_log[k] !== 1'b0) n_fetch++;
    chk("t6_fetch_acks", n_fetch, 0);
`endif
    tick();
    log_en = 1'b0;
    bus.d_req = 1'b0; bus.if_req = 1'b0;
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
